// File: rtl/mtr_pkg.sv
// Shared widths, speed type and helpers for the motor PWM driver.
// Optional dead-time build: define MTR_PWM_DEADTIME_EN.
package mtr_pkg;

   localparam int unsigned PWM_W  = 11;
   localparam int unsigned DUTY_W = 12;

   localparam logic [PWM_W-1:0] PER_MAX  = 11'h7FF;
   localparam logic [PWM_W-1:0] DUTY_MID = 11'h400;

   typedef logic signed [PWM_W-1:0] spd_t;

   localparam spd_t SPD_MIN     = spd_t'(11'h400);
   localparam spd_t SPD_MIN_SAT = spd_t'(11'h401);

   // -1024 would give duty1 = 0; clamp it so PWM1 always has at least one high clock.
   function automatic spd_t sat_spd(input spd_t s);
      return (s == SPD_MIN) ? SPD_MIN_SAT : s;
   endfunction

   // duty1 = 1024 + spd, evaluated in 12 bits with the speed sign-extended.
   function automatic logic [DUTY_W-1:0] duty_of(input spd_t s);
      return {1'b0, DUTY_MID} + {s[PWM_W-1], s};
   endfunction

endpackage

// File: rtl/mtr_pwm_drv_pair.sv
// One registered complementary PWM pair driven from the shared period counter.
// With MTR_PWM_DEADTIME_EN defined, each rising edge is delayed by DEAD_CYC clocks.
module pwm11_pair
   import mtr_pkg::*;
#(
   parameter int unsigned DEAD_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PWM_W-1:0]  cnt,
   input  logic [DUTY_W-1:0] duty1,
   output logic              pwm1,
   output logic              pwm2
);

   logic [DUTY_W-1:0] cnt_x;
   logic              pwm1_d;
   logic              pwm1_q;
   logic              pwm2_d;
   logic              pwm2_q;

   assign cnt_x = {1'b0, cnt};

`ifdef MTR_PWM_DEADTIME_EN
   localparam logic [DUTY_W-1:0] DEAD = DUTY_W'(DEAD_CYC);

   // duty1 <= 2047 and DEAD <= 63, so duty1 + DEAD cannot wrap 12 bits.
   always_comb begin
      pwm1_d = 1'b0;
      pwm2_d = 1'b0;
      pwm1_d = (cnt_x >= DEAD) && (cnt_x < duty1);
      pwm2_d = (cnt_x >= (duty1 + DEAD));
   end
`else
   always_comb begin
      pwm1_d = 1'b0;
      pwm2_d = 1'b0;
      pwm1_d = (cnt_x < duty1);
      pwm2_d = ~pwm1_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm1_q <= 1'b0;
         pwm2_q <= 1'b0;
      end else begin
         pwm1_q <= pwm1_d;
         pwm2_q <= pwm2_d;
      end
   end

   assign pwm1 = pwm1_q;
   assign pwm2 = pwm2_q;

endmodule

// File: rtl/mtr_pwm_drv.sv
// Dual H-bridge PWM driver: 2048-clock period, shadowed speed commands applied at the wrap.
// Optional dead-time build: define MTR_PWM_DEADTIME_EN (uses DEAD_CYC).
module mtr_pwm_drv
   import mtr_pkg::*;
#(
   parameter int unsigned DEAD_CYC = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [PWM_W-1:0] lft_spd,
   input  logic signed [PWM_W-1:0] rght_spd,
   input  logic                    spd_vld,
   output logic                    upd_pend,
   output logic                    per_strt,
   output logic                    lftPWM1,
   output logic                    lftPWM2,
   output logic                    rghtPWM1,
   output logic                    rghtPWM2
);

   logic [PWM_W-1:0] cnt_d;
   logic [PWM_W-1:0] cnt_q;
   logic             run_d;
   logic             run_q;
   logic             per_strt_d;
   logic             per_strt_q;
   logic             upd_pend_d;
   logic             upd_pend_q;
   spd_t             lft_sh_d;
   spd_t             lft_sh_q;
   spd_t             rght_sh_d;
   spd_t             rght_sh_q;
   spd_t             lft_act_d;
   spd_t             lft_act_q;
   spd_t             rght_act_d;
   spd_t             rght_act_q;
   spd_t             lft_in_sat;
   spd_t             rght_in_sat;
   logic             boundary;

   logic [DUTY_W-1:0] lft_duty;
   logic [DUTY_W-1:0] rght_duty;

   assign lft_in_sat  = sat_spd(lft_spd);
   assign rght_in_sat = sat_spd(rght_spd);
   assign boundary    = run_q && (cnt_q == PER_MAX);

   // cnt holds 0 for one edge after reset so the first running cycle shows cnt==0 with per_strt.
   always_comb begin
      cnt_d      = cnt_q;
      run_d      = 1'b1;
      per_strt_d = 1'b0;
      upd_pend_d = upd_pend_q;
      lft_sh_d   = lft_sh_q;
      rght_sh_d  = rght_sh_q;
      lft_act_d  = lft_act_q;
      rght_act_d = rght_act_q;

      cnt_d      = run_q ? (cnt_q + PWM_W'(1)) : '0;
      per_strt_d = (cnt_d == '0);

      if (spd_vld) begin
         lft_sh_d   = lft_in_sat;
         rght_sh_d  = rght_in_sat;
         upd_pend_d = 1'b1;
      end

      // A strobe coinciding with the wrap goes straight to the active registers.
      if (boundary) begin
         lft_act_d  = spd_vld ? lft_in_sat  : lft_sh_q;
         rght_act_d = spd_vld ? rght_in_sat : rght_sh_q;
         upd_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         run_q      <= 1'b0;
         per_strt_q <= 1'b0;
         upd_pend_q <= 1'b0;
         lft_sh_q   <= '0;
         rght_sh_q  <= '0;
         lft_act_q  <= '0;
         rght_act_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         run_q      <= run_d;
         per_strt_q <= per_strt_d;
         upd_pend_q <= upd_pend_d;
         lft_sh_q   <= lft_sh_d;
         rght_sh_q  <= rght_sh_d;
         lft_act_q  <= lft_act_d;
         rght_act_q <= rght_act_d;
      end
   end

   assign lft_duty  = duty_of(lft_act_q);
   assign rght_duty = duty_of(rght_act_q);

   pwm11_pair #(
      .DEAD_CYC (DEAD_CYC)
   ) u_lft (
      .clk   (clk),
      .rst   (rst),
      .cnt   (cnt_q),
      .duty1 (lft_duty),
      .pwm1  (lftPWM1),
      .pwm2  (lftPWM2)
   );

   pwm11_pair #(
      .DEAD_CYC (DEAD_CYC)
   ) u_rght (
      .clk   (clk),
      .rst   (rst),
      .cnt   (cnt_q),
      .duty1 (rght_duty),
      .pwm1  (rghtPWM1),
      .pwm2  (rghtPWM2)
   );

   assign upd_pend = upd_pend_q;
   assign per_strt = per_strt_q;

endmodule
